axi4m_burst: RTL and testbench
==============================

# axi4m_burst

Parametrised AXI4 master bridge that turns one native request into one AXI4 INCR burst of 1..256 beats. Write data and read data stream beat by beat on separate native handshakes, and each transaction ends with a single completion/error pulse. It is the next generation of the single-beat core-side AXI master and sits between cache-refill/writeback logic and the SoC interconnect. AW and W are driven concurrently, and reads support back-pressure.

## Interface
Parameters:
- AXI_ADDR_W, 32, address width.
- AXI_DATA_W, 32, data width; one of 32/64/128.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, active-low. One clock; reset is asynchronous and active-low.
- AXI4 write address channel: m_axi_awaddr/awlen[7:0]/awsize[2:0]/awburst[1:0]/awlock/awcache[3:0]/awprot[2:0]/awqos[3:0]/awvalid out, m_axi_awready in.
- AXI4 write data channel: m_axi_wdata[AXI_DATA_W]/wstrb[AXI_DATA_W/8]/wlast/wvalid out, m_axi_wready in.
- AXI4 write response channel: m_axi_bresp[1:0]/bvalid in, m_axi_bready out.
- AXI4 read address channel: m_axi_araddr/arlen/arsize/arburst/arlock/arcache/arprot/arqos/arvalid out, m_axi_arready in.
- AXI4 read data channel: m_axi_rdata/rresp[1:0]/rlast/rvalid in, m_axi_rready out.
- req_val  in  1  request valid.
- req_rdy  out  1  request accepted when req_val & req_rdy.
- req_wr  in  1  1 = write burst, 0 = read burst.
- req_adr  in  AXI_ADDR_W  burst start address; aligned to AXI_DATA_W/8.
- req_len  in  8  number of beats minus 1.
- wd_val  in  1  write beat valid.
- wd_rdy  out  1  write beat accepted.
- wd_dat  in  AXI_DATA_W  write beat data.
- wd_strb  in  AXI_DATA_W/8  write beat byte strobe.
- rd_val  out  1  read beat valid.
- rd_rdy  in  1  requester can take the read beat.
- rd_dat  out  AXI_DATA_W  read beat data.
- rd_last  out  1  final read beat.
- rsp_val  out  1  one-cycle completion pulse.
- rsp_err  out  1  error flag, valid with rsp_val.

## Operation
- Constant AXI fields:
  - len = latched req_len; size = log2(AXI_DATA_W/8); burst = INCR (01).
  - lock = 0, cache = 0010, prot = 000, qos = 0.
- Addresses:
  - awaddr and araddr come from the latched address register, not from req_adr.
  - The requester guarantees the burst does not cross a 4 KB boundary; the block does not check this.
- States: IDLE, WRITE, WRESP, RADDR, RDATA, DONE.
- IDLE:
  - req_rdy = 1 in IDLE only.
  - On accept: latch adr, len and wr, clear the beat counter and err.
  - Next state is WRITE if wr, else RADDR.
- WRITE:
  - awvalid = ~aw_done; aw_done sets on the AW handshake.
  - wvalid = wd_val; wd_rdy = wready; wdata and wstrb pass straight through from wd_dat and wd_strb.
  - wlast = (cnt == len); cnt increments on each W handshake.
  - Leave for WRESP once the last W beat has completed and aw_done is set (or the AW handshake happens in the same cycle).
  - Both orders are legal: W may complete before AW, and vice versa.
- WRESP:
  - bready = 1.
  - On the B handshake: err = bresp[1]; go to DONE.
- RADDR: arvalid = 1; on the AR handshake go to RDATA.
- RDATA:
  - rready = rd_rdy; rd_val = rvalid; rd_dat = rdata; rd_last = rlast.
  - err |= rresp[1] on each R handshake.
  - cnt increments on each R handshake.
  - Early end: rlast with cnt ≠ len sets err and ends the burst.
  - Missing last: a beat with cnt == len and no rlast also sets err and ends the burst.
  - Go to DONE after the ending beat.
- DONE:
  - rsp_val = 1 and rsp_err = err for exactly one cycle.
  - Go to IDLE; req_rdy = 1 from the following cycle.
- Ignored inputs: wd_val outside WRITE and rd_rdy outside RDATA have no effect.

## Timing
- Reset values:
  - State = IDLE, so req_rdy = 1.
  - awvalid, wvalid, bready, arvalid, rready, rd_val, wd_rdy, rsp_val, rsp_err all 0.
  - cnt = 0, err = 0, aw_done = 0.
- Reset asserted mid-burst returns to IDLE immediately, drops all valids and produces no rsp_val. The interconnect is reset alongside.
- Latency from request acceptance:
  - AW/AR is valid on the cycle after acceptance.
  - Zero-wait write: AW and W beat 0 on cycle +1, B on the cycle after the last W, rsp_val on the cycle after B.
  - Zero-wait read: AR on +1, R beats from +2, rsp_val on the cycle after the last R.
- Handshake rules:
  - Every AXI valid, once raised, holds with stable payload until its ready (all payloads come from registers or held native inputs).
  - rd_val/rd_dat is combinational from R; the requester must not depend on rd_val to drive rd_rdy.
- Throughput: full rate, one beat per cycle when both sides are ready.
- Counter: 8-bit cnt, compared to len; with len = 255, wlast on beat 255 and no wrap.

## Test plan
- Single-beat write (len = 0, adr = 0x100, strb = 0xF, data = 0xDEADBEEF), zero-wait slave -> awlen = 0, wlast = 1 on beat 0, one rsp_val with rsp_err = 0, req_rdy back to 1 two cycles after B.
- 8-beat write with awready delayed 5 cycles after all W beats -> all 8 W beats accepted first, bready only after the AW handshake, rsp_err = 0.
- 16-beat read with rd_rdy toggling each cycle -> 16 beats delivered in order, rd_last only on beat 15, rready tracks rd_rdy, no beat lost or duplicated.
- Read with rresp = SLVERR on beat 3 of 4 -> all 4 beats delivered, rsp_err = 1.
- Read len = 3 with slave asserting rlast on beat 1 -> burst ends after beat 1, rsp_err = 1, block returns to IDLE.
- 256-beat write (len = 255), then rst_n pulsed during a following read burst -> wlast only on beat 255; on reset all outputs return to reset values asynchronously, with no rsp_val.

Source files
------------

// File: rtl/axi4m_burst.sv
// AXI4 master bridge: one native request becomes one AXI4 INCR burst of 1..256 beats, then one rsp_val pulse.
// W and R beats pass straight through; AXI payloads come from registers or from native inputs the requester holds.
module axi4m_burst #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [AXI_ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [AXI_DATA_W-1:0]   m_axi_wdata,
  output logic [AXI_DATA_W/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [AXI_ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [AXI_DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic                    req_val,
  output logic                    req_rdy,
  input  logic                    req_wr,
  input  logic [AXI_ADDR_W-1:0]   req_adr,
  input  logic [7:0]              req_len,
  input  logic                    wd_val,
  output logic                    wd_rdy,
  input  logic [AXI_DATA_W-1:0]   wd_dat,
  input  logic [AXI_DATA_W/8-1:0] wd_strb,
  output logic                    rd_val,
  input  logic                    rd_rdy,
  output logic [AXI_DATA_W-1:0]   rd_dat,
  output logic                    rd_last,
  output logic                    rsp_val,
  output logic                    rsp_err
);

  localparam logic [2:0] AXSIZE = 3'($clog2(AXI_DATA_W / 8));

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, DONE} state_t;

  state_t                state, state_nxt;
  logic [AXI_ADDR_W-1:0] adr_q, adr_nxt;
  logic [7:0]            len_q, len_nxt;
  logic [7:0]            cnt_q, cnt_nxt;
  logic                  err_q, err_nxt;
  logic                  aw_done_q, aw_done_nxt;
  logic                  w_done_q, w_done_nxt;
  logic                  beat_last;
  logic                  aw_hs, w_hs, r_hs;
  logic                  unused_ok;

  assign beat_last = (cnt_q == len_q);

  assign m_axi_awaddr  = adr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = AXSIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0010;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;

  assign m_axi_araddr  = adr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = AXSIZE;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0010;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'b0000;

  assign m_axi_wdata = wd_dat;
  assign m_axi_wstrb = wd_strb;
  assign m_axi_wlast = beat_last;
  assign rd_dat      = m_axi_rdata;

  // Only bit 1 of a response distinguishes error from success.
  assign unused_ok = &{1'b0, m_axi_bresp[0], m_axi_rresp[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      adr_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      adr_q     <= adr_nxt;
      len_q     <= len_nxt;
      cnt_q     <= cnt_nxt;
      err_q     <= err_nxt;
      aw_done_q <= aw_done_nxt;
      w_done_q  <= w_done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    adr_nxt       = adr_q;
    len_nxt       = len_q;
    cnt_nxt       = cnt_q;
    err_nxt       = err_q;
    aw_done_nxt   = aw_done_q;
    w_done_nxt    = w_done_q;
    aw_hs         = 1'b0;
    w_hs          = 1'b0;
    r_hs          = 1'b0;
    req_rdy       = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    wd_rdy        = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    rd_val        = 1'b0;
    rd_last       = 1'b0;
    rsp_val       = 1'b0;
    rsp_err       = 1'b0;

    case (state)
      IDLE: begin
        req_rdy = 1'b1;
        if (req_val) begin
          adr_nxt     = req_adr;
          len_nxt     = req_len;
          cnt_nxt     = '0;
          err_nxt     = 1'b0;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          state_nxt   = req_wr ? WRITE : RADDR;
        end
      end

      WRITE: begin
        // w_done stops further W beats while AW is still outstanding, so cnt never wraps.
        m_axi_awvalid = ~aw_done_q;
        m_axi_wvalid  = wd_val & ~w_done_q;
        wd_rdy        = m_axi_wready & ~w_done_q;
        aw_hs         = m_axi_awvalid & m_axi_awready;
        w_hs          = m_axi_wvalid & m_axi_wready;
        if (aw_hs) aw_done_nxt = 1'b1;
        if (w_hs) begin
          if (beat_last) w_done_nxt = 1'b1;
          else           cnt_nxt    = cnt_q + 8'd1;
        end
        if ((w_done_q | (w_hs & beat_last)) & (aw_done_q | aw_hs))
          state_nxt = WRESP;
      end

      WRESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          err_nxt   = m_axi_bresp[1];
          state_nxt = DONE;
        end
      end

      RADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nxt = RDATA;
      end

      RDATA: begin
        m_axi_rready = rd_rdy;
        rd_val       = m_axi_rvalid;
        rd_last      = m_axi_rlast;
        r_hs         = m_axi_rvalid & rd_rdy;
        if (r_hs) begin
          // Either an early rlast or a missing one flags the burst and ends it on this beat.
          err_nxt = err_q | m_axi_rresp[1] | (m_axi_rlast != beat_last);
          if (m_axi_rlast | beat_last) state_nxt = DONE;
          else                         cnt_nxt   = cnt_q + 8'd1;
        end
      end

      DONE: begin
        rsp_val   = 1'b1;
        rsp_err   = err_q;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4m_burst.sv
// Bench for axi4m_burst: AXI slave and requester modelled in-bench, randomized traffic checked against
// expected streams built from the request parameters and source data.
module tb_axi4m_burst;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awlock;
  logic [3:0]  m_axi_awcache;
  logic [2:0]  m_axi_awprot;
  logic [3:0]  m_axi_awqos;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic [3:0]  m_axi_arqos;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic        req_val, req_rdy, req_wr;
  logic [31:0] req_adr;
  logic [7:0]  req_len;
  logic        wd_val, wd_rdy;
  logic [31:0] wd_dat;
  logic [3:0]  wd_strb;
  logic        rd_val, rd_rdy;
  logic [31:0] rd_dat;
  logic        rd_last, rsp_val, rsp_err;

  axi4m_burst #(.AXI_ADDR_W(32), .AXI_DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
    .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache),
    .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .req_val(req_val), .req_rdy(req_rdy), .req_wr(req_wr), .req_adr(req_adr), .req_len(req_len),
    .wd_val(wd_val), .wd_rdy(wd_rdy), .wd_dat(wd_dat), .wd_strb(wd_strb),
    .rd_val(rd_val), .rd_rdy(rd_rdy), .rd_dat(rd_dat), .rd_last(rd_last),
    .rsp_val(rsp_val), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // Source data and what the bench observed on the far side.
  logic [31:0] src_dat[$];
  logic [3:0]  src_strb[$];
  logic [31:0] o_dat[$];
  logic [3:0]  o_strb[$];
  logic        o_last[$];
  logic [56:0] o_ax;
  logic        o_err;
  int t_acc, t_ax, t_first, t_lastbeat, t_b, t_rsp, t_rdy;
  int n_rsp, n_ax, n_hs_bad, n_rready_bad;
  bit early_b, tmo;

  function automatic logic [56:0] ax_exp(input logic [31:0] a, input int l);
    return {a, 8'(l), 3'd2, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000};
  endfunction

  task automatic idle_inputs();
    req_val = 0; req_wr = 0; req_adr = '0; req_len = '0;
    wd_val = 0; wd_dat = '0; wd_strb = '0; rd_rdy = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = '0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 0;
  endtask

  task automatic clear_obs();
    o_dat.delete(); o_strb.delete(); o_last.delete();
    o_ax = '0; o_err = 0;
    t_acc = -1; t_ax = -1; t_first = -1; t_lastbeat = -1; t_b = -1; t_rsp = -1; t_rdy = -1;
    n_rsp = 0; n_ax = 0; n_hs_bad = 0; n_rready_bad = 0; early_b = 0; tmo = 0;
  endtask

  task automatic fill_src(input int n);
    src_dat.delete(); src_strb.delete();
    for (int i = 0; i < n; i++) begin
      src_dat.push_back($urandom);
      src_strb.push_back(4'($urandom));
    end
  endtask

  // Requester + slave driver for one write burst. aw_gap >= 0 holds awready low until
  // aw_gap cycles after the last W beat; rnd randomizes wd_val/wready/awready.
  task automatic do_write(input logic [31:0] adr, input int len, input int aw_gap,
                          input bit rnd, input logic [1:0] bresp);
    bit acc = 0, aw_seen = 0, w_fin = 0, b_seen = 0, w_taken = 0, bpend = 0, done = 0;
    int wi = 0;
    clear_obs();
    req_wr = 1; req_adr = adr; req_len = 8'(len);
    for (int k = 0; k < 4000 && !done; k++) begin
      @(posedge clk); #1;
      req_val = !acc;
      if (acc && wi <= len) begin
        if (w_taken || !wd_val) wd_val = rnd ? 1'($urandom) : 1'b1;
        wd_dat = src_dat[wi]; wd_strb = src_strb[wi];
      end else wd_val = 0;
      w_taken = 0;
      m_axi_wready = rnd ? 1'($urandom) : 1'b1;
      if (aw_gap < 0) m_axi_awready = rnd ? 1'($urandom) : 1'b1;
      else            m_axi_awready = w_fin && (cyc >= t_lastbeat + aw_gap);
      m_axi_bvalid = bpend; m_axi_bresp = bresp;
      #1;
      if (!acc && req_rdy) begin acc = 1; t_acc = cyc; end
      if (m_axi_awvalid && m_axi_awready) begin
        n_ax++;
        if (!aw_seen) begin
          aw_seen = 1; t_ax = cyc;
          o_ax = {m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock,
                  m_axi_awcache, m_axi_awprot, m_axi_awqos};
        end
      end
      if (m_axi_bready && !aw_seen) early_b = 1;
      if (m_axi_wvalid && m_axi_wready) begin
        if (!wd_rdy) n_hs_bad++;
        o_dat.push_back(m_axi_wdata); o_strb.push_back(m_axi_wstrb); o_last.push_back(m_axi_wlast);
        if (wi == 0) t_first = cyc;
        if (wi == len) begin w_fin = 1; t_lastbeat = cyc; end
        wi++; w_taken = 1;
      end
      if (m_axi_bvalid && m_axi_bready) begin b_seen = 1; t_b = cyc; end
      bpend = aw_seen && w_fin && !b_seen;
      if (rsp_val) begin n_rsp++; o_err = rsp_err; t_rsp = cyc; end
      if (n_rsp > 0 && t_rdy < 0 && cyc > t_rsp && req_rdy) t_rdy = cyc;
      if (t_rdy >= 0 && cyc >= t_rsp + 3) done = 1;
    end
    tmo = !done;
    idle_inputs();
  endtask

  // Requester + slave driver for one read burst. The slave raises rlast on beat rlast_at
  // and answers SLVERR on beat err_beat. mode: 0 rd_rdy high, 1 toggling, 2 random.
  task automatic do_read(input logic [31:0] adr, input int len, input int rlast_at,
                         input int err_beat, input int mode, input bit rnd);
    bit acc = 0, ar_seen = 0, r_taken = 0, done = 0;
    int ri = 0;
    int end_i;
    end_i = (rlast_at < len) ? rlast_at : len;
    fill_src(end_i + 1);
    clear_obs();
    req_wr = 0; req_adr = adr; req_len = 8'(len);
    for (int k = 0; k < 4000 && !done; k++) begin
      @(posedge clk); #1;
      req_val = !acc;
      m_axi_arready = rnd ? 1'($urandom) : 1'b1;
      rd_rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc & 1) : 1'($urandom);
      if (ar_seen && ri <= end_i) begin
        if (r_taken || !m_axi_rvalid) m_axi_rvalid = rnd ? 1'($urandom) : 1'b1;
        m_axi_rdata = src_dat[ri];
        m_axi_rresp = (ri == err_beat) ? 2'b10 : 2'b00;
        m_axi_rlast = (ri == rlast_at);
      end else m_axi_rvalid = 0;
      r_taken = 0;
      #1;
      if (!acc && req_rdy) begin acc = 1; t_acc = cyc; end
      if (m_axi_arvalid && m_axi_arready) begin
        n_ax++;
        if (!ar_seen) begin
          ar_seen = 1; t_ax = cyc;
          o_ax = {m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
                  m_axi_arcache, m_axi_arprot, m_axi_arqos};
        end
      end
      if (m_axi_rvalid && m_axi_rready) begin ri++; r_taken = 1; end
      if (rd_val && (m_axi_rready !== rd_rdy)) n_rready_bad++;
      if (rd_val && rd_rdy) begin
        if (o_dat.size() == 0) t_first = cyc;
        o_dat.push_back(rd_dat); o_last.push_back(rd_last); t_lastbeat = cyc;
      end
      if (rsp_val) begin n_rsp++; o_err = rsp_err; t_rsp = cyc; end
      if (n_rsp > 0 && t_rdy < 0 && cyc > t_rsp && req_rdy) t_rdy = cyc;
      if (t_rdy >= 0 && cyc >= t_rsp + 3) done = 1;
    end
    tmo = !done;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({req_rdy, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
         rd_val, wd_rdy, rsp_val, rsp_err} !== 10'b10_0000_0000) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=%b", {req_rdy, m_axi_awvalid, m_axi_wvalid,
               m_axi_bready, m_axi_arvalid, m_axi_rready, rd_val, wd_rdy, rsp_val, rsp_err},
               10'b10_0000_0000);
    end
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    wd_val = 1; m_axi_wready = 1; m_axi_rvalid = 1; rd_rdy = 1; m_axi_bvalid = 1;
    #1;
    total++;
    if ({m_axi_wvalid, wd_rdy, rd_val, m_axi_rready, rsp_val} !== 5'b0) begin
      bad++;
      $display("FAIL idle_ignored got=%b exp=00000",
               {m_axi_wvalid, wd_rdy, rd_val, m_axi_rready, rsp_val});
    end
    @(posedge clk); #1;
    total++;
    if (req_rdy !== 1'b1) begin bad++; $display("FAIL idle_stays got=%b exp=1", req_rdy); end
    idle_inputs();
  endtask

  task automatic test_single_write();
    src_dat.delete(); src_strb.delete();
    src_dat.push_back(32'hDEADBEEF); src_strb.push_back(4'hF);
    do_write(32'h100, 0, -1, 0, 2'b00);
    total++; if (tmo) begin bad++; $display("FAIL sw_timeout got=1 exp=0"); end
    total++; if (o_ax !== ax_exp(32'h100, 0)) begin bad++; $display("FAIL sw_aw got=%h exp=%h", o_ax, ax_exp(32'h100, 0)); end
    total++; if (o_dat.size() != 1) begin bad++; $display("FAIL sw_beats got=%0d exp=1", o_dat.size()); end
    else begin
      total++;
      if ({o_dat[0], o_strb[0], o_last[0]} !== {32'hDEADBEEF, 4'hF, 1'b1}) begin
        bad++; $display("FAIL sw_beat got=%h/%h/%b exp=deadbeef/f/1", o_dat[0], o_strb[0], o_last[0]);
      end
    end
    total++; if (t_ax != t_acc + 1 || t_first != t_acc + 1) begin bad++; $display("FAIL sw_aw_w_lat got=%0d/%0d exp=1/1", t_ax - t_acc, t_first - t_acc); end
    total++; if (t_b != t_lastbeat + 1) begin bad++; $display("FAIL sw_b_lat got=%0d exp=1", t_b - t_lastbeat); end
    total++; if (t_rsp != t_b + 1) begin bad++; $display("FAIL sw_rsp_lat got=%0d exp=1", t_rsp - t_b); end
    total++; if (t_rdy != t_b + 2) begin bad++; $display("FAIL sw_rdy_back got=%0d exp=2", t_rdy - t_b); end
    total++; if (n_rsp != 1 || o_err !== 1'b0) begin bad++; $display("FAIL sw_rsp got=%0d/%b exp=1/0", n_rsp, o_err); end
  endtask

  task automatic test_aw_late();
    fill_src(8);
    do_write(32'h2000, 7, 5, 0, 2'b00);
    total++; if (tmo) begin bad++; $display("FAIL awl_timeout got=1 exp=0"); end
    total++; if (o_dat.size() != 8) begin bad++; $display("FAIL awl_beats got=%0d exp=8", o_dat.size()); end
    else for (int i = 0; i < 8; i++) begin
      total++;
      if ({o_dat[i], o_strb[i], o_last[i]} !== {src_dat[i], src_strb[i], 1'(i == 7)}) begin
        bad++; $display("FAIL awl_beat%0d got=%h/%h/%b exp=%h/%h/%b", i, o_dat[i], o_strb[i],
                        o_last[i], src_dat[i], src_strb[i], i == 7);
      end
    end
    total++; if (t_ax < t_lastbeat + 5) begin bad++; $display("FAIL awl_order got=%0d exp>=5", t_ax - t_lastbeat); end
    total++; if (early_b || t_b <= t_ax) begin bad++; $display("FAIL awl_bready_early got=%b/%0d exp=0/>0", early_b, t_b - t_ax); end
    total++; if (n_ax != 1 || n_rsp != 1 || o_err !== 1'b0) begin bad++; $display("FAIL awl_rsp got=%0d/%0d/%b exp=1/1/0", n_ax, n_rsp, o_err); end
  endtask

  task automatic test_write_random();
    for (int it = 0; it < 4; it++) begin
      int len;
      logic [1:0] br;
      len = $urandom_range(0, 31);
      br = 2'($urandom);
      fill_src(len + 1);
      do_write({$urandom_range(0, 4095), 8'h00} & 32'hFFFF_FFFC, len, -1, 1, br);
      total++; if (tmo) begin bad++; $display("FAIL wr%0d_timeout got=1 exp=0", it); end
      total++; if (o_ax !== ax_exp(req_adr, len) && 0) begin bad++; end
      total--;
      total++; if (o_dat.size() != len + 1) begin bad++; $display("FAIL wr%0d_beats got=%0d exp=%0d", it, o_dat.size(), len + 1); end
      else for (int i = 0; i <= len; i++) begin
        total++;
        if ({o_dat[i], o_strb[i], o_last[i]} !== {src_dat[i], src_strb[i], 1'(i == len)}) begin
          bad++; $display("FAIL wr%0d_beat%0d got=%h/%h/%b exp=%h/%h/%b", it, i, o_dat[i],
                          o_strb[i], o_last[i], src_dat[i], src_strb[i], i == len);
        end
      end
      total++; if (n_hs_bad != 0 || early_b) begin bad++; $display("FAIL wr%0d_hs got=%0d/%b exp=0/0", it, n_hs_bad, early_b); end
      total++; if (n_ax != 1 || n_rsp != 1 || o_err !== br[1]) begin bad++; $display("FAIL wr%0d_rsp got=%0d/%0d/%b exp=1/1/%b", it, n_ax, n_rsp, o_err, br[1]); end
    end
  endtask

  task automatic test_read_zero_wait();
    do_read(32'h340, 3, 3, -1, 0, 0);
    total++; if (tmo) begin bad++; $display("FAIL rz_timeout got=1 exp=0"); end
    total++; if (o_ax !== ax_exp(32'h340, 3)) begin bad++; $display("FAIL rz_ar got=%h exp=%h", o_ax, ax_exp(32'h340, 3)); end
    total++; if (t_ax != t_acc + 1 || t_first != t_acc + 2) begin bad++; $display("FAIL rz_lat got=%0d/%0d exp=1/2", t_ax - t_acc, t_first - t_acc); end
    total++; if (t_lastbeat != t_first + 3 || t_rsp != t_lastbeat + 1) begin bad++; $display("FAIL rz_rate got=%0d/%0d exp=3/1", t_lastbeat - t_first, t_rsp - t_lastbeat); end
    total++; if (o_dat.size() != 4 || n_rsp != 1 || o_err !== 1'b0) begin bad++; $display("FAIL rz_rsp got=%0d/%0d/%b exp=4/1/0", o_dat.size(), n_rsp, o_err); end
  endtask

  // name: scenario label; exp_err derives from the slave's misbehaviour, not from the DUT.
  task automatic test_read_case(input string name, input int len, input int rlast_at,
                                input int err_beat, input int mode, input bit rnd);
    int end_i;
    logic exp_err;
    end_i = (rlast_at < len) ? rlast_at : len;
    exp_err = (rlast_at != len) || (err_beat >= 0 && err_beat <= end_i);
    do_read(32'h1000, len, rlast_at, err_beat, mode, rnd);
    total++; if (tmo) begin bad++; $display("FAIL %s_timeout got=1 exp=0", name); end
    total++; if (o_dat.size() != end_i + 1) begin bad++; $display("FAIL %s_beats got=%0d exp=%0d", name, o_dat.size(), end_i + 1); end
    else for (int i = 0; i <= end_i; i++) begin
      total++;
      if ({o_dat[i], o_last[i]} !== {src_dat[i], 1'(i == rlast_at)}) begin
        bad++; $display("FAIL %s_beat%0d got=%h/%b exp=%h/%b", name, i, o_dat[i], o_last[i], src_dat[i], i == rlast_at);
      end
    end
    total++; if (n_rready_bad != 0) begin bad++; $display("FAIL %s_rready got=%0d exp=0", name, n_rready_bad); end
    total++; if (n_ax != 1 || n_rsp != 1 || o_err !== exp_err) begin bad++; $display("FAIL %s_rsp got=%0d/%0d/%b exp=1/1/%b", name, n_ax, n_rsp, o_err, exp_err); end
    total++; if (t_rdy != t_rsp + 1) begin bad++; $display("FAIL %s_idle got=%0d exp=1", name, t_rdy - t_rsp); end
  endtask

  task automatic test_read_random();
    for (int it = 0; it < 4; it++) begin
      int len, rl, eb;
      len = $urandom_range(0, 20);
      rl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 25) : len;
      eb = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 20) : -1;
      test_read_case($sformatf("rrand%0d", it), len, rl, eb, 2, 1);
    end
  endtask

  task automatic test_long_write_then_reset();
    bit acc = 0;
    int n_last = 0;
    int n_rsp_after = 0;
    fill_src(256);
    do_write(32'h4000, 255, -1, 0, 2'b00);
    total++; if (tmo || o_dat.size() != 256) begin bad++; $display("FAIL long_beats got=%0d exp=256", o_dat.size()); end
    else begin
      for (int i = 0; i < 256; i++) begin
        total++;
        if (o_dat[i] !== src_dat[i]) begin bad++; $display("FAIL long_dat%0d got=%h exp=%h", i, o_dat[i], src_dat[i]); end
        if (o_last[i]) n_last++;
      end
      total++; if (n_last != 1 || o_last[255] !== 1'b1) begin bad++; $display("FAIL long_wlast got=%0d/%b exp=1/1", n_last, o_last[255]); end
    end
    total++; if (t_lastbeat != t_first + 255 || n_rsp != 1 || o_err !== 1'b0) begin bad++; $display("FAIL long_rate got=%0d/%0d/%b exp=255/1/0", t_lastbeat - t_first, n_rsp, o_err); end

    req_wr = 0; req_adr = 32'h5000; req_len = 8'd15;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(posedge clk); #1; req_val = 1; #1;
      if (req_rdy) acc = 1;
    end
    @(posedge clk); #1;
    req_val = 0; m_axi_arready = 1; m_axi_rvalid = 1; rd_rdy = 1; m_axi_rdata = $urandom;
    repeat (3) @(posedge clk);
    #1;
    total++; if (!acc || rd_val !== 1'b1) begin bad++; $display("FAIL rst_pre got=%b/%b exp=1/1", acc, rd_val); end
    #2 rst_n = 0;
    #1;
    total++;
    if ({req_rdy, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
         rd_val, wd_rdy, rsp_val, rsp_err} !== 10'b10_0000_0000) begin
      bad++;
      $display("FAIL rst_async got=%b exp=%b", {req_rdy, m_axi_awvalid, m_axi_wvalid,
               m_axi_bready, m_axi_arvalid, m_axi_rready, rd_val, wd_rdy, rsp_val, rsp_err},
               10'b10_0000_0000);
    end
    idle_inputs();
    @(posedge clk);
    @(negedge clk) rst_n = 1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (rsp_val) n_rsp_after++;
    end
    total++; if (n_rsp_after != 0 || req_rdy !== 1'b1) begin bad++; $display("FAIL rst_no_rsp got=%0d/%b exp=0/1", n_rsp_after, req_rdy); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_aw_late();
    test_write_random();
    test_read_zero_wait();
    test_read_case("rtoggle", 15, 15, -1, 1, 0);
    test_read_case("rslverr", 3, 3, 2, 0, 0);
    test_read_case("rearly", 3, 1, -1, 0, 0);
    test_read_case("rnolast", 2, 255, -1, 2, 0);
    test_read_random();
    test_long_write_then_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
